// File: rtl/dpcm_if.sv
// dpcm_if: block request/response bundle between a DPCM block source/sink and the decoder.
interface dpcm_if #(parameter int W = 8, parameter int N = 16);
  logic start, mode, finish_ack, start_ack, finish, err;
  logic [N*(W+1)-1:0] data_in;
  logic [N*W-1:0] data_out;
  modport slave(input start, mode, data_in, finish_ack, output start_ack, finish, err, data_out);
  modport master(output start, mode, data_in, finish_ack, input start_ack, finish, err, data_out);
endinterface

// File: rtl/dpcm_decoder.sv
// dpcm_decoder: rebuilds a 4x4 DPCM-coded block, one pixel per cycle along a serpentine scan.
module dpcm_decoder #(
  parameter int W = 8,
  parameter int N = 16,
  parameter int LOGN = 4
) (
  input logic clk,
  input logic rst,
  dpcm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECON, DONE} state_t;
  state_t state_q, state_d;
  logic [0:N-1][W:0] data_q, data_d;
  logic [0:N-1][W-1:0] buf_q, buf_d, out_q, out_d;
  logic mode_q, mode_d, start_ack_q, start_ack_d, finish_q, finish_d, err_q, err_d;
  logic [W-1:0] acc_q, acc_d, pix;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [W+1:0] sum;
  logic [W:0] fld;
  // scan position -> raster index; odd rows (mode 0) or odd columns (mode 1) run backwards
  function automatic logic [LOGN-1:0] raster(input logic m, input logic [LOGN-1:0] k);
    logic [1:0] lane;
    lane = k[2] ? ~k[1:0] : k[1:0];
    return m ? {lane, k[3:2]} : {k[3:2], lane};
  endfunction
  assign fld = data_q[cnt_q];
  assign sum = fld[W] ? {2'b0, acc_q} - {2'b0, fld[W-1:0]} : {2'b0, acc_q} + {2'b0, fld[W-1:0]};
  assign pix = sum[W+1] ? '0 : sum[W] ? '1 : sum[W-1:0];
  assign bus.start_ack = start_ack_q;
  assign bus.finish = finish_q;
  assign bus.err = err_q;
  assign bus.data_out = out_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q <= '0;
      buf_q <= '0;
      out_q <= '0;
      mode_q <= 1'b0;
      start_ack_q <= 1'b0;
      finish_q <= 1'b0;
      err_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      buf_q <= buf_d;
      out_q <= out_d;
      mode_q <= mode_d;
      start_ack_q <= start_ack_d;
      finish_q <= finish_d;
      err_q <= err_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    buf_d = buf_q;
    out_d = out_q;
    mode_d = mode_q;
    start_ack_d = 1'b0;
    finish_d = finish_q;
    err_d = err_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        data_d = bus.data_in;
        mode_d = bus.mode;
        acc_d = bus.data_in[N*(W+1)-2 -: W];
        buf_d[0] = bus.data_in[N*(W+1)-2 -: W];
        cnt_d = {{(LOGN-1){1'b0}}, 1'b1};
        start_ack_d = 1'b1;
        err_d = 1'b0;
        state_d = RECON;
      end
      RECON: begin
        buf_d[raster(mode_q, cnt_q)] = pix;
        acc_d = pix;
        err_d = err_q | sum[W+1] | sum[W];
        cnt_d = cnt_q + 1'b1;
        // publish only complete blocks so data_out never shows a half-decoded mix
        if (&cnt_q) begin
          out_d = buf_d;
          finish_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (bus.finish_ack) begin
        finish_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/dpcm_decoder.md
DPCM_DECODER -- requirements
Module: dpcm_decoder

Interface
REQ-001 Parameter W, 8, pixel width in bits.
REQ-002 Parameter N, 16, pixels per 4x4 block.
REQ-003 Parameter LOGN, 4, counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  request: a coded block is present on data_in/mode.
REQ-007 mode  input  1  scan order: 0 = row serpentine, 1 = column serpentine.
REQ-008 data_in  input  N*(W+1)=144  coded block, 16 fields of 9 bits, field 0 at bits [143:135].
REQ-009 finish_ack  input  1  consumer has taken data_out.
REQ-010 start_ack  output  1  one-cycle pulse: block accepted.
REQ-011 finish  output  1  data_out valid, held until acknowledged.
REQ-012 err  output  1  at least one reconstructed pixel saturated in the current block.
REQ-013 data_out  output  N*W=128  reconstructed block, raster order, pixel (r,c) at bits [127-8*(4r+c) -: 8].

Function
REQ-014 Field 0 SHALL be {x, first pixel in scan order}; bit 8 is ignored.
REQ-015 Field k (k=1..15) SHALL be {sign, magnitude}: sign=1 means p_k = p_(k-1) - magnitude, sign=0 means p_k = p_(k-1) + magnitude.
REQ-016 Mode 0 scan SHALL be row 0 left-to-right, row 1 right-to-left, row 2 left-to-right, row 3 right-to-left.
REQ-017 Mode 1 scan SHALL be column 0 top-to-bottom, column 1 bottom-to-top, column 2 top-to-bottom, column 3 bottom-to-top.
REQ-018 The FSM SHALL have states IDLE, RECON, DONE; the reset state is IDLE.
REQ-019 In IDLE with start=1 at an edge, the block SHALL latch data_in and mode, load the accumulator with field 0, write scan pixel 0, set cnt=1, set start_ack=1, clear err, and enter RECON.
REQ-020 start_ack SHALL return to 0 on the next edge; start is ignored in RECON and DONE.
REQ-021 In RECON, each edge SHALL reconstruct one pixel from the accumulator and field[cnt], write it to scan position cnt, update the accumulator, and increment cnt.
REQ-022 Arithmetic SHALL be 10-bit signed; a result >255 saturates to 255 and a result <0 saturates to 0.
REQ-023 On saturation, err SHALL be set (sticky for the block), and the accumulator SHALL carry the saturated value.
REQ-024 On the edge that writes cnt=15, the FSM SHALL enter DONE and set finish=1. finish is therefore visible 15 edges after the accept edge.
REQ-025 In DONE, data_out and err SHALL hold stable; finish_ack=1 at an edge clears finish and returns to IDLE.
REQ-026 If start=1 in the same cycle as finish_ack, the start SHALL be accepted only at a later edge in IDLE; the minimum gap is 1 cycle.
REQ-027 data_out SHALL remain at the last block's values until the next block completes; partial results are not guaranteed until finish=1.

Reset
REQ-028 With rst=0, the block SHALL be in IDLE with start_ack=0, finish=0, err=0, data_out=0, cnt=0, and accumulator=0, regardless of the clock.
REQ-029 Reset asserted during RECON or DONE SHALL abandon the block. After release, finish remains 0 until a new block is fully decoded.

Verification
REQ-030 Mode 0: field0=0x010, fields 1-15=0x001 -> rows {10,11,12,13},{17,16,15,14},{18,19,1A,1B},{1F,1E,1D,1C}; err=0.
REQ-031 Mode 1, same data_in -> row 0 = {10,17,18,1F}, column 0 = {10,11,12,13}; err=0.
REQ-032 Flat block: field0=0x064, fields=0x000 or 0x100 -> all 16 pixels 0x64 in both modes.
REQ-033 Saturation: field0=0xF0, fields=0x020 -> scan pixel 0=F0, rest FF, err=1; field0=0x10 with fields 0x120 -> pixel 0=10, rest 00, err=1.
REQ-034 Handshake: start held high throughout -> exactly one start_ack pulse; finish rises exactly 15 edges after the accept edge; finish_ack delayed 5 cycles -> data_out and finish held stable; the next start is accepted only after returning to IDLE.
REQ-035 Reset mid-RECON at cnt=7 -> all outputs 0 immediately. A subsequent full block then decodes correctly per REQ-030.
